// File: rtl/pio_in_conditioner.sv
// pio_in_conditioner
//
// Front end for the 8-bit Avalon input PIO. Every raw input bit (keys,
// switches, compute-core status lines) is brought into the clk domain through
// a flop chain and then debounced on its own counter, so pio_data only ever
// changes after an input has been stable for a full debounce window. Accepted
// rising edges (and, optionally, falling edges) latch sticky per-bit flags,
// and irq summarises them.
//
// Parameters
//   WIDTH            number of conditioned bits
//   SYNC_STAGES      synchronizer flops per bit (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change (>= 1)
//   CNT_W            debounce counter width, must hold DEBOUNCE_CYCLES-1
//
// Ports
//   clk          in   1      system clock
//   reset        in   1      asynchronous, active-high reset
//   raw_in       in   WIDTH  asynchronous raw inputs
//   clear_edges  in   WIDTH  write-one-to-clear pulse for edge_flags
//   pio_data     out  WIDTH  debounced, registered level for the PIO in_port
//   edge_flags   out  WIDTH  sticky per-bit edge-detected flags
//   irq          out  1      registered OR of edge_flags
//
// Build option
//   PIO_COND_BOTH_EDGES_EN  when defined, accepted 1->0 transitions also set
//                           edge_flags; otherwise only 0->1 transitions do.

module pio_in_conditioner #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] clear_edges,
  output logic [WIDTH-1:0] pio_data,
  output logic [WIDTH-1:0] edge_flags,
  output logic             irq
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_d;
  logic [WIDTH-1:0]                  stable_d;
  logic [WIDTH-1:0]                  accept;
  logic [WIDTH-1:0]                  edge_set;
  logic [WIDTH-1:0]                  flags_d;

  // Synchronizer chain: stage 0 samples the raw pins, the last stage is the
  // first point where the value is safe to use in clk-domain logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Per-bit debounce. A bit that disagrees with its accepted level counts up;
  // any return to the accepted level restarts the count, and reaching the
  // terminal count commits the new level and rearms the counter.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = pio_data;
    accept   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == pio_data[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == TERM_CNT) begin
        cnt_d[i]    = '0;
        stable_d[i] = s[i];
        accept[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Which accepted transitions latch a flag. A set in the same cycle as a
  // clear must win, so the set term is ORed in after the clear mask.
`ifdef PIO_COND_BOTH_EDGES_EN
  assign edge_set = accept;
`else
  assign edge_set = accept & stable_d;
`endif

  assign flags_d = (edge_flags & ~clear_edges) | edge_set;

  // Debounce state, flags and irq all update on the same edge so irq never
  // lags the flags it summarises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      pio_data   <= '0;
      edge_flags <= '0;
      irq        <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pio_data   <= stable_d;
      edge_flags <= flags_d;
      irq        <= |flags_d;
    end
  end

endmodule
